// File: rtl/ecc_pkg.sv
// Shared definitions for the X25519 scalar-multiplication blocks:
// ladder sequencer state encoding and curve-size constants.
package ecc_pkg;

  localparam int NBITS_X25519 = 255;
  localparam int WID_X25519   = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWAP   = 3'd1,
    SWWAIT = 3'd2,
    STEP   = 3'd3,
    STWAIT = 3'd4,
    FSWAP  = 3'd5,
    FWAIT  = 3'd6,
    DONE   = 3'd7
  } ladder_state_t;

endpackage

// File: rtl/x25519_clamp.sv
// RFC 7748 scalar clamping: clear bits 2:0 and the top bit, set the next-to-top bit.
module x25519_clamp #(
  parameter int WID = 256
) (
  input  logic [WID-1:0] k_in,
  output logic [WID-1:0] k_out
);

  localparam logic [WID-1:0] CLR_MASK = ~((WID'(1) << (WID-1)) | WID'(7));
  localparam logic [WID-1:0] SET_MASK = WID'(1) << (WID-2);

  assign k_out = (k_in & CLR_MASK) | SET_MASK;

endmodule

// File: rtl/ladder_ctrl.sv
// Montgomery-ladder sequencer: per scalar bit, one conditional swap then one
// ladder step, followed by a final swap. All outputs are registered.
module ladder_ctrl
  import ecc_pkg::*;
#(
  parameter int WID   = WID_X25519,
  parameter int NBITS = NBITS_X25519,
  parameter int CNTW  = 8,
  parameter int CLAMP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WID-1:0]  scalar,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] bit_idx,
  output logic            sw_en,
  output logic            sw_swap,
  input  logic            sw_vld,
  output logic            step_start,
  input  logic            step_done
);

  localparam logic [CNTW-1:0] IDX_TOP = CNTW'(NBITS-1);

  ladder_state_t   state;
  logic [WID-1:0]  k_in;
  logic [WID-1:0]  k_reg;
  logic            prev;
  logic            cur_bit;
  logic [CNTW-1:0] idx_dn;

  if (CLAMP != 0) begin : g_clamp
    x25519_clamp #(.WID(WID)) u_clamp (
      .k_in  (scalar),
      .k_out (k_in)
    );
  end else begin : g_noclamp
    assign k_in = scalar;
  end

  assign cur_bit = k_reg[bit_idx];
  assign idx_dn  = bit_idx - 1'b1;

  // Each state name marks the cycle in which its pulse is visible, so the
  // pulse registers are loaded on the transition into that state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sw_en      <= 1'b0;
      sw_swap    <= 1'b0;
      step_start <= 1'b0;
      bit_idx    <= IDX_TOP;
      k_reg      <= '0;
      prev       <= 1'b0;
    end else begin
      sw_en      <= 1'b0;
      step_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_reg   <= k_in;
            bit_idx <= IDX_TOP;
            prev    <= 1'b0;
            busy    <= 1'b1;
            sw_en   <= 1'b1;
            sw_swap <= k_in[NBITS-1];
            state   <= SWAP;
          end
        end
        SWAP: state <= SWWAIT;
        SWWAIT: begin
          if (sw_vld) begin
            step_start <= 1'b1;
            state      <= STEP;
          end
        end
        STEP: state <= STWAIT;
        STWAIT: begin
          if (step_done) begin
            prev  <= cur_bit;
            sw_en <= 1'b1;
            if (bit_idx == '0) begin
              sw_swap <= cur_bit;
              state   <= FSWAP;
            end else begin
              bit_idx <= idx_dn;
              sw_swap <= k_reg[idx_dn] ^ cur_bit;
              state   <= SWAP;
            end
          end
        end
        FSWAP: state <= FWAIT;
        FWAIT: begin
          if (sw_vld) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ladder_ctrl.sv
// Directed bench for ladder_ctrl: one unclamped and one clamped instance, each
// with a 2-cycle cswap model and a 3-cycle ladder-step model.
module tb_ladder_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b1;
  logic [1:0]   start = 2'b00;
  logic [255:0] scalar = '0;

  logic [1:0]   busy, done, sw_en, sw_swap, sw_vld, step_start, step_done;
  logic [7:0]   bit_idx [2];
  int           en_cnt [2];
  int           st_cnt [2];
  int           dn_cnt [2];
  logic [255:0] swlog [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic         en_d1 = 1'b0;
    logic         vld   = 1'b0;
    logic         st_d1 = 1'b0;
    logic         st_d2 = 1'b0;
    logic         sdone = 1'b0;
    int           n_en  = 0;
    int           n_st  = 0;
    int           n_dn  = 0;
    logic [255:0] log_v = '0;

    ladder_ctrl #(.WID(256), .NBITS(255), .CNTW(8), .CLAMP(gi)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[gi]),
      .scalar     (scalar),
      .busy       (busy[gi]),
      .done       (done[gi]),
      .bit_idx    (bit_idx[gi]),
      .sw_en      (sw_en[gi]),
      .sw_swap    (sw_swap[gi]),
      .sw_vld     (sw_vld[gi]),
      .step_start (step_start[gi]),
      .step_done  (step_done[gi])
    );

    always @(posedge clk) begin
      en_d1 <= sw_en[gi];
      vld   <= en_d1;
      st_d1 <= step_start[gi];
      st_d2 <= st_d1;
      sdone <= st_d2;
    end
    assign sw_vld[gi]    = vld;
    assign step_done[gi] = sdone;

    // Pulse monitor: bit i of log_v is sw_swap at the i-th sw_en pulse.
    always @(negedge clk) begin
      if (clr) begin
        n_en  <= 0;
        n_st  <= 0;
        n_dn  <= 0;
        log_v <= '0;
      end else begin
        if (sw_en[gi]) begin
          if (n_en < 256) log_v[n_en] <= sw_swap[gi];
          n_en <= n_en + 1;
        end
        if (step_start[gi]) n_st <= n_st + 1;
        if (done[gi])       n_dn <= n_dn + 1;
      end
    end
    assign en_cnt[gi] = n_en;
    assign st_cnt[gi] = n_st;
    assign dn_cnt[gi] = n_dn;
    assign swlog[gi]  = log_v;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int g, input string tag);
    for (int i = 0; i < 6000 && !done[g]; i++) tick;
    check({tag, "_done_seen"}, 256'(done[g]), 256'd1);
  endtask

  task automatic finish_op(input int g, input logic [255:0] exp_log, input string tag);
    wait_done(g, tag);
    check({tag, "_busy_at_done"}, 256'(busy[g]), 256'd0);
    tick;
    check({tag, "_done_one_cycle"}, 256'(done[g]), 256'd0);
    tick;
    check({tag, "_sw_en_count"}, 256'(en_cnt[g]), 256'd256);
    check({tag, "_step_count"}, 256'(st_cnt[g]), 256'd255);
    check({tag, "_done_count"}, 256'(dn_cnt[g]), 256'd1);
    check({tag, "_swap_log"}, swlog[g], exp_log);
    $display("%s: en=%0d steps=%0d done=%0d log=%0h", tag, en_cnt[g], st_cnt[g], dn_cnt[g], swlog[g]);
  endtask

  task automatic run_op(input int g, input logic [255:0] k, input logic [255:0] exp_log, input string tag);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    scalar = k;
    start[g] = 1'b1;
    tick;
    start[g] = 1'b0;
    finish_op(g, exp_log, tag);
  endtask

  initial begin
    logic [255:0] k;
    logic [255:0] e;

    rst = 1'b0;
    repeat (3) tick;
    for (int g = 0; g < 2; g++) begin
      check("reset_outs", 256'({busy[g], done[g], sw_en[g], sw_swap[g], step_start[g]}), 256'd0);
      check("reset_bit_idx", 256'(bit_idx[g]), 256'd254);
    end
    $display("reset: busy=%b done=%b bit_idx=%0d/%0d", busy, done, bit_idx[0], bit_idx[1]);
    rst = 1'b1;
    clr = 1'b0;
    tick;

    // scalar 0: no swaps at all
    run_op(0, '0, '0, "t1_zero");

    // only bit 254 set: swaps at t=254 and t=253
    k = '0;
    k[254] = 1'b1;
    run_op(0, k, 256'h3, "t2_bit254");

    // even bits set: every neighbouring pair differs, final swap = k[0] = 1
    run_op(0, {64{4'h5}}, '1, "t3_even_bits");

    // clamped all-ones: swaps at t=254 (i=0) and t=2 (i=252)
    e = '0;
    e[0]   = 1'b1;
    e[252] = 1'b1;
    run_op(1, '1, e, "t4_clamp_ones");

    // latency and start-while-busy
    clr = 1'b1;
    tick;
    clr = 1'b0;
    scalar = '0;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    check("t5_c1_sw_en", 256'(sw_en[0]), 256'd1);
    check("t5_c1_busy", 256'(busy[0]), 256'd1);
    tick;
    check("t5_c2_sw_en_low", 256'(sw_en[0]), 256'd0);
    tick;
    check("t5_c3_sw_vld", 256'(sw_vld[0]), 256'd1);
    tick;
    check("t5_c4_step_start", 256'(step_start[0]), 256'd1);
    $display("t5_latency: sw_en@1 sw_vld@3 step_start@4 checked");
    repeat (5) tick;
    scalar = '1;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    finish_op(0, '0, "t5_ignored_start");

    // reset in STWAIT at t=100
    clr = 1'b1;
    tick;
    clr = 1'b0;
    scalar = {64{4'h5}};
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (step_start[0] && bit_idx[0] == 8'd100) break;
      tick;
    end
    check("t6_reached_t100", 256'({step_start[0], bit_idx[0]}), 256'({1'b1, 8'd100}));
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("t6_rst_outs", 256'({busy[0], done[0], sw_en[0], sw_swap[0], step_start[0]}), 256'd0);
    check("t6_rst_bit_idx", 256'(bit_idx[0]), 256'd254);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    repeat (8) tick;
    check("t6_no_sw_en_after_rst", 256'(en_cnt[0]), 256'd0);
    check("t6_no_step_after_rst", 256'(st_cnt[0]), 256'd0);
    check("t6_idle_after_rst", 256'(busy[0]), 256'd0);
    $display("t6_abort: en=%0d steps=%0d busy=%b", en_cnt[0], st_cnt[0], busy[0]);
    run_op(0, {64{4'h5}}, '1, "t6_rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ladder_ctrl.md
Name: ladder_ctrl

Overview:
Sequencer for the X25519 Montgomery-ladder scalar multiplication core. Walks the latched scalar from bit NBITS-1 down to bit 0. Each iteration it:
- drives the cswap block with swap = k_t XOR k_(t+1),
- waits for cswap valid,
- launches one ladder step (double-and-add datapath) and waits for it to finish.
After bit 0 it issues the final conditional swap and signals done. Sits between the scalar-mult top FSM and the cswap / ladder-step datapaths.

Parameters:
- WID, 256, scalar and operand width
- NBITS, 255, number of ladder iterations (scalar bits NBITS-1..0 processed)
- CNTW, 8, width of the bit-index counter; must satisfy 2^CNTW > NBITS
- CLAMP, 1, when 1 apply RFC 7748 clamping to the latched scalar (bits 2:0 cleared, bit 255 cleared, bit 254 set)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets)
- start  in  1  request; accepted only in IDLE
- scalar  in  WID  scalar k, sampled on the accepted start cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at completion
- bit_idx  out  CNTW  index t of the iteration in progress
- sw_en  out  1  one-cycle enable pulse to cswap
- sw_swap  out  1  swap select to cswap, valid while sw_en=1
- sw_vld  in  1  cswap output valid
- step_start  out  1  one-cycle pulse launching a ladder step
- step_done  in  1  ladder step complete (one-cycle pulse)

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; busy, done, sw_en, sw_swap, step_start = 0; bit_idx = NBITS-1; k_reg = 0; prev = 0. Reset mid-operation aborts immediately. No further pulses are emitted, and pending sw_vld/step_done are ignored.
- All outputs are registered.
- States and transitions:
  - IDLE: on start=1 → latch k_reg (clamped if CLAMP), set bit_idx = NBITS-1, prev = 0, go to SWAP.
  - SWAP: sw_en=1 for one cycle, sw_swap = k_reg[bit_idx] ^ prev → SWWAIT.
  - SWWAIT: hold until sw_vld=1 → STEP.
  - STEP: step_start=1 for one cycle → STWAIT.
  - STWAIT: on step_done=1:
    - prev ← k_reg[bit_idx];
    - if bit_idx==0 → FSWAP;
    - else bit_idx ← bit_idx-1 and go to SWAP.
  - FSWAP: sw_en=1, sw_swap = prev → FWAIT.
  - FWAIT: on sw_vld=1 → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Timing: start sampled at edge N gives busy=1 and sw_en=1 in cycle N+1. With the standard cswap (2-cycle en→vld), sw_vld is seen in N+3 and step_start in N+4.
- Totals per operation: exactly NBITS+1 sw_en pulses and NBITS step_start pulses.
- start while busy is ignored; scalar changes while busy are ignored.
- sw_vld outside SWWAIT/FWAIT is ignored. step_done outside STWAIT is ignored.
- sw_vld and step_done are never expected in the same cycle; each is consumed only in its own wait state.
- A new start may be accepted in the cycle after done (IDLE).
- bit_idx never wraps: decrement is suppressed at 0.

Decomposition:
- Shared package ecc_pkg holds:
  - state encoding constants (IDLE, SWAP, SWWAIT, STEP, STWAIT, FSWAP, FWAIT, DONE, 3 bits),
  - X25519 constants NBITS_X25519=255 and WID_X25519=256.
- Clamping is a natural single combinational sub-module, x25519_clamp (WID in, WID out), instantiated when CLAMP=1.
- The FSM, counter and pulse registers stay in ladder_ctrl.

Test Plan:
1. CLAMP=0, scalar=0, cswap real instance, step_done returned 3 cycles after each step_start:
   - all sw_swap=0;
   - 256 sw_en and 255 step_start pulses;
   - done pulses once; busy then drops.
2. CLAMP=0, scalar=1<<254:
   - sw_swap=1 at t=254 and t=253, 0 for t=252..0;
   - final swap=0.
3. CLAMP=0, scalar=0x5555…5 (even bits set):
   - sw_swap=1 every iteration 254..0;
   - final swap=1.
4. CLAMP=1, scalar=all ones:
   - sw_swap=1 at t=254, 0 at t=253..3, 1 at t=2, 0 at t=1,0;
   - final swap=0.
5. Latency check: start at cycle 0 → sw_en cycle 1, sw_vld cycle 3, step_start cycle 4. Pulse start again at cycle 10 → ignored (pulse counts unchanged vs test 1).
6. rst=0 asserted while in STWAIT at t=100:
   - next cycle all outputs 0, bit_idx=254;
   - late step_done ignored;
   - subsequent start runs a full, correct sequence.
